// File: rtl/mul_arb_pkg.sv
// Shared types and width helpers for the multiplier arbiter.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int W_DEF  = 8;
  localparam int PW_DEF = 2 * W_DEF + 1;

  function automatic int prod_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/mul_arb_if.sv
// Bundles the requester-side and multiplier-side buses of the arbiter.
interface mul_arb_if #(
  parameter int NREQ = 2,
  parameter int W    = mul_arb_pkg::W_DEF
);
  localparam int PW = mul_arb_pkg::prod_width(W);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              err;
  logic [PW-1:0]     result;
  logic              busy;
  logic [W-1:0]      m_a;
  logic [W-1:0]      m_b;
  logic              m_start;
  logic [PW-1:0]     m_o;
  logic              m_fin;

  // Arbiter view.
  modport master (
    input  req, a_in, b_in, m_o, m_fin,
    output gnt, done, err, result, busy, m_a, m_b, m_start
  );

  // Clients plus multiplier view.
  modport slave (
    output req, a_in, b_in, m_o, m_fin,
    input  gnt, done, err, result, busy, m_a, m_b, m_start
  );

endinterface

// File: rtl/mul_rr_pick.sv
// Combinational round-robin pick: first set request after the pointer,
// wrapping, returned as one-hot plus index.
module mul_rr_pick #(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx
);

  logic [IW-1:0] cand_s;
  logic          found_s;

  // Scan from ptr+1 upward, keeping the first requester found.
  always_comb begin
    win     = '0;
    win_idx = '0;
    cand_s  = '0;
    found_s = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      cand_s = IW'((int'(ptr) + off) % NREQ);
      if (!found_s && req[cand_s]) begin
        win[cand_s] = 1'b1;
        win_idx     = cand_s;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mul_arb.sv
// Round-robin sequencer sharing one multi-cycle multiplier among NREQ
// requesters; latches operands at grant and guards m_fin with a timeout.
module mul_arb
  import mul_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic      ck,
  input  logic      rst,
  mul_arb_if.master bus
);

  localparam int PW = prod_width(W);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_RST  = IW'(NREQ - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic [PW-1:0]   result_q, result_d;
  logic            busy_q, busy_d;
  logic [W-1:0]    m_a_q, m_a_d;
  logic [W-1:0]    m_b_q, m_b_d;
  logic            m_start_q, m_start_d;

  logic [NREQ-1:0] win_s;
  logic [IW-1:0]   win_idx_s;

  mul_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win     (win_s),
    .win_idx (win_idx_s)
  );

  // Next-state and next-output logic; outputs are all registered.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = 1'b0;
    result_d  = result_q;
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    m_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d     = win_s;
          idx_d     = win_idx_s;
          m_a_d     = bus.a_in[int'(win_idx_s)*W +: W];
          m_b_d     = bus.b_in[int'(win_idx_s)*W +: W];
          m_start_d = 1'b1;
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // m_fin has priority over the timeout when both land on the same edge.
        if (bus.m_fin) begin
          result_d = bus.m_o;
          done_d   = gnt_q;
          state_d  = DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = gnt_q;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        ptr_d   = idx_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any in-flight product.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_RST;
      idx_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
      m_start_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
      m_start_q <= m_start_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.result  = result_q;
  assign bus.busy    = busy_q;
  assign bus.m_a     = m_a_q;
  assign bus.m_b     = m_b_q;
  assign bus.m_start = m_start_q;

endmodule
